// File: rtl/snax_csr_pkg.sv
// Shared definitions for the SNAX CSR responder.
//   ctrl_start_bit : bit of a CTRL write that requests an accelerator start
//   csr_class_e    : address-decode class of a zero-based CSR index
//   csr_decode()   : maps a 32-bit CSR index to its class for N RW and M RO CSRs
package snax_csr_pkg;

  localparam int unsigned CtrlStartBit = 0;

  typedef enum logic [1:0] {
    CsrRw,
    CsrRo,
    CsrCtrl,
    CsrUnmapped
  } csr_class_e;

  // Full 32-bit comparisons so that large indices never alias into the map.
  function automatic csr_class_e csr_decode(input logic [31:0] addr,
                                            input int unsigned num_rw,
                                            input int unsigned num_ro);
    logic [31:0] n;
    logic [31:0] nm;
    n  = num_rw;
    nm = num_rw + num_ro;
    if (addr < n) begin
      return CsrRw;
    end else if (addr < nm) begin
      return CsrRo;
    end else if (addr == nm) begin
      return CsrCtrl;
    end else begin
      return CsrUnmapped;
    end
  endfunction

endpackage

// File: rtl/fifo_v3.sv
// Synchronous FIFO, port-compatible subset of common_cells fifo_v3 (no fall-through).
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset (storage, pointers and count cleared)
//   flush_i : synchronous clear of all queued entries
//   full_o  : no free entry; a same-cycle pop does not make room for a push
//   empty_o : no entry queued
//   data_i  : write data, stored when push_i && !full_o
//   push_i  : write request
//   data_o  : head entry, stable until popped
//   pop_i   : read request, honoured when !empty_o
module fifo_v3 #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  output logic                  full_o,
  output logic                  empty_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            do_push, do_pop;

  assign full_o  = (cnt_q == FullCnt);
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!do_push && do_pop) begin
      cnt_d = cnt_q - 1'b1;
    end
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '0;
    end else if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/snax_csr_responder.sv
// Accelerator-side endpoint of the simplified SNAX CSR port.
// Holds NumRwCsr read-write configuration CSRs, exposes NumRoCsr read-only status
// CSRs and a CTRL CSR (write bit 0 = start, read bit 0 = busy). Reads are answered
// through a RspDepth-entry response FIFO; writes produce no response.
//   clk_i / rst_i               : clock, asynchronous active-high reset
//   snax_csr_req_bits_*_i       : request data / zero-based index / write flag
//   snax_csr_req_valid_i/ready_o: request handshake
//   snax_csr_rsp_bits_data_o    : read response data
//   snax_csr_rsp_valid_o/ready_i: response handshake
//   csr_rw_o                    : current RW CSR values
//   csr_ro_i                    : status values returned by RO reads
//   acc_start_o                 : one-cycle start pulse after an accepted start write
//   acc_busy_i                  : accelerator busy; stalls RW and CTRL writes
module snax_csr_responder
  import snax_csr_pkg::*;
#(
  parameter int unsigned NumRwCsr = 8,
  parameter int unsigned NumRoCsr = 2,
  parameter int unsigned RspDepth = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [31:0]                snax_csr_req_bits_data_i,
  input  logic [31:0]                snax_csr_req_bits_addr_i,
  input  logic                       snax_csr_req_bits_write_i,
  input  logic                       snax_csr_req_valid_i,
  output logic                       snax_csr_req_ready_o,
  output logic [31:0]                snax_csr_rsp_bits_data_o,
  output logic                       snax_csr_rsp_valid_o,
  input  logic                       snax_csr_rsp_ready_i,
  output logic [NumRwCsr-1:0][31:0]  csr_rw_o,
  input  logic [NumRoCsr-1:0][31:0]  csr_ro_i,
  output logic                       acc_start_o,
  input  logic                       acc_busy_i
);

  csr_class_e                req_class;
  logic                      accept;
  logic                      rw_write;
  logic                      start_req;
  logic                      rsp_push;
  logic                      rsp_pop;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [31:0]               rd_data;
  logic [NumRwCsr-1:0][31:0] rw_q;
  logic                      start_q;

  assign req_class = csr_decode(snax_csr_req_bits_addr_i, NumRwCsr, NumRoCsr);

  // Busy only gates writes that touch accelerator configuration or start it;
  // reads are gated solely by response space, other writes are always sunk.
  always_comb begin
    snax_csr_req_ready_o = 1'b0;
    if (!rst_i) begin
      if (!snax_csr_req_bits_write_i) begin
        snax_csr_req_ready_o = ~fifo_full;
      end else if (req_class == CsrRw || req_class == CsrCtrl) begin
        snax_csr_req_ready_o = ~acc_busy_i;
      end else begin
        snax_csr_req_ready_o = 1'b1;
      end
    end
  end

  assign accept    = snax_csr_req_valid_i & snax_csr_req_ready_o;
  assign rw_write  = accept & snax_csr_req_bits_write_i & (req_class == CsrRw);
  assign start_req = accept & snax_csr_req_bits_write_i & (req_class == CsrCtrl) &
                     snax_csr_req_bits_data_i[CtrlStartBit];
  assign rsp_push  = accept & ~snax_csr_req_bits_write_i;

  // Read mux; sampled into the FIFO at the accepting edge.
  always_comb begin
    rd_data = '0;
    unique case (req_class)
      CsrRw: begin
        for (int unsigned i = 0; i < NumRwCsr; i++) begin
          if (snax_csr_req_bits_addr_i == 32'(i)) begin
            rd_data = rw_q[i];
          end
        end
      end
      CsrRo: begin
        for (int unsigned j = 0; j < NumRoCsr; j++) begin
          if (snax_csr_req_bits_addr_i == 32'(NumRwCsr + j)) begin
            rd_data = csr_ro_i[j];
          end
        end
      end
      CsrCtrl: rd_data = {31'b0, acc_busy_i};
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rw_q <= '0;
    end else if (rw_write) begin
      for (int unsigned i = 0; i < NumRwCsr; i++) begin
        if (snax_csr_req_bits_addr_i == 32'(i)) begin
          rw_q[i] <= snax_csr_req_bits_data_i;
        end
      end
    end
  end

  // Registered straight from the accept cycle, so the pulse covers exactly the
  // following cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      start_q <= 1'b0;
    end else begin
      start_q <= start_req;
    end
  end

  assign csr_rw_o    = rw_q;
  assign acc_start_o = start_q;

  assign snax_csr_rsp_valid_o = ~fifo_empty;
  assign rsp_pop              = snax_csr_rsp_valid_o & snax_csr_rsp_ready_i;

  fifo_v3 #(
    .DATA_WIDTH(32),
    .DEPTH     (RspDepth)
  ) i_rsp_fifo (
    .clk_i  (clk_i),
    .rst_ni (~rst_i),
    .flush_i(1'b0),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .data_i (rd_data),
    .push_i (rsp_push),
    .data_o (snax_csr_rsp_bits_data_o),
    .pop_i  (rsp_pop)
  );

endmodule

// File: tb/tb_snax_csr_responder.sv
module tb_snax_csr_responder;

  localparam int unsigned N = 8;
  localparam int unsigned M = 2;
  localparam int unsigned D = 2;
  localparam logic [31:0] CtrlAddr = N + M;

  logic              clk;
  logic              rst;
  logic [31:0]       req_data;
  logic [31:0]       req_addr;
  logic              req_write;
  logic              req_valid;
  logic              req_ready;
  logic [31:0]       rsp_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [N-1:0][31:0] csr_rw;
  logic [M-1:0][31:0] csr_ro;
  logic              start;
  logic              busy;

  snax_csr_responder #(
    .NumRwCsr(N),
    .NumRoCsr(M),
    .RspDepth(D)
  ) dut (
    .clk_i                    (clk),
    .rst_i                    (rst),
    .snax_csr_req_bits_data_i (req_data),
    .snax_csr_req_bits_addr_i (req_addr),
    .snax_csr_req_bits_write_i(req_write),
    .snax_csr_req_valid_i     (req_valid),
    .snax_csr_req_ready_o     (req_ready),
    .snax_csr_rsp_bits_data_o (rsp_data),
    .snax_csr_rsp_valid_o     (rsp_valid),
    .snax_csr_rsp_ready_i     (rsp_ready),
    .csr_rw_o                 (csr_rw),
    .csr_ro_i                 (csr_ro),
    .acc_start_o              (start),
    .acc_busy_i               (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: register contents, expected response queue, expected start.
  logic [31:0] m_rw [N];
  logic [31:0] m_q [$];
  logic        exp_start = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_rw(input string tag);
    logic [N*32-1:0] exp;
    for (int i = 0; i < N; i++) exp[i*32 +: 32] = m_rw[i];
    checks++;
    assert (csr_rw === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, csr_rw, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a < N) return m_rw[a];
    if (a < N + M) return csr_ro[a-N];
    if (a == CtrlAddr) return {31'b0, busy};
    return 32'h0;
  endfunction

  function automatic logic model_ready(input logic w, input logic [31:0] a);
    if (rst) return 1'b0;
    if (!w) return m_q.size() < D;
    if (a < N || a == CtrlAddr) return !busy;
    return 1'b1;
  endfunction

  task automatic model_clear();
    m_q.delete();
    for (int i = 0; i < N; i++) m_rw[i] = 32'h0;
    exp_start = 1'b0;
  endtask

  // One clock cycle: drive, check at the falling edge, advance the model.
  task automatic step(input logic v, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic rr, output logic acc);
    logic exp_rdy;
    logic nstart;
    req_valid = v;
    req_write = w;
    req_addr  = a;
    req_data  = d;
    rsp_ready = rr;
    @(negedge clk);
    exp_rdy = model_ready(w, a);
    if (v) chk("req_ready", req_ready, exp_rdy);
    chk("rsp_valid", rsp_valid, m_q.size() != 0);
    if (m_q.size() != 0) chk("rsp_data", rsp_data, m_q[0]);
    chk_rw("csr_rw");
    chk("acc_start", start, exp_start);
    acc    = v && exp_rdy;
    nstart = 1'b0;
    if (m_q.size() != 0 && rr) void'(m_q.pop_front());
    if (acc) begin
      if (!w) m_q.push_back(model_read(a));
      else if (a < N) m_rw[a] = d;
      else if (a == CtrlAddr && d[0]) nstart = 1'b1;
    end
    @(posedge clk);
    #1;
    exp_start = nstart;
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic rr);
    logic acc = 1'b0;
    int   n   = 0;
    while (!acc && n < 20) begin
      step(1'b1, w, a, d, rr, acc);
      n++;
    end
    chk("accept_bound", acc, 1'b1);
  endtask

  task automatic idle(input int n, input logic rr);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0, rr, acc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        acc;
    logic        v, w, rr;
    logic [31:0] a, d;

    rst       = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h0;
    req_data  = 32'h0;
    rsp_ready = 1'b1;
    busy      = 1'b0;
    csr_ro[0] = 32'hA5A5_0001;
    csr_ro[1] = 32'hA5A5_0002;
    model_clear();

    // Reset state
    #2;
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_start", start, 1'b0);
    chk("rst_ready", req_ready, 1'b0);
    chk_rw("rst_csr_rw");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Read the whole map plus one unmapped index, one per cycle
    for (int i = 0; i <= N + M + 1; i++) issue(1'b0, 32'(i), 32'h0, 1'b1);
    idle(2, 1'b1);

    // Write then read back on the next cycle
    issue(1'b1, 32'd3, 32'hDEAD_BEEF, 1'b1);
    issue(1'b0, 32'd3, 32'h0, 1'b1);
    idle(2, 1'b1);

    // RW write stalls while busy, accepted when busy drops
    busy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 32'd1, 32'h5, 1'b1, acc);
      chk("busy_stall", acc, 1'b0);
    end
    busy = 1'b0;
    issue(1'b1, 32'd1, 32'h5, 1'b1);
    idle(2, 1'b1);

    // Start pulse, then a CTRL write of 0 gives none; CTRL read sees busy
    issue(1'b1, CtrlAddr, 32'h1, 1'b1);
    idle(3, 1'b1);
    issue(1'b1, CtrlAddr, 32'h0, 1'b1);
    idle(3, 1'b1);
    busy = 1'b1;
    issue(1'b0, CtrlAddr, 32'h0, 1'b1);
    busy = 1'b0;
    idle(2, 1'b1);

    // Response back-pressure: D reads fill the FIFO, the next stalls
    issue(1'b0, 32'd3, 32'h0, 1'b0);
    issue(1'b0, 32'd1, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, N, 32'h0, 1'b0, acc);
      chk("full_stall", acc, 1'b0);
    end
    issue(1'b0, N, 32'h0, 1'b1);
    idle(4, 1'b1);

    // Randomized traffic, including large indices that must not alias
    for (int i = 0; i < 400; i++) begin
      busy = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) begin
        csr_ro[0] = $urandom;
        csr_ro[1] = $urandom;
      end
      v  = ($urandom_range(0, 3) != 0);
      w  = $urandom_range(0, 1) == 1;
      rr = ($urandom_range(0, 3) != 0);
      d  = $urandom;
      if ($urandom_range(0, 7) == 0) a = (32'h100 << $urandom_range(0, 23)) | $urandom_range(0, N + M);
      else a = $urandom_range(0, N + M + 2);
      step(v, w, a, d, rr, acc);
    end
    busy = 1'b0;
    idle(6, 1'b1);

    // Reset mid-operation with two queued responses
    issue(1'b1, 32'd0, 32'h7, 1'b0);
    issue(1'b0, 32'd0, 32'h0, 1'b0);
    issue(1'b0, 32'd3, 32'h0, 1'b0);
    req_valid = 1'b0;
    #2;
    chk("pre_rst_valid", rsp_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", rsp_valid, 1'b0);
    chk("mid_rst_rw0", csr_rw[0], 32'h0);
    chk("mid_rst_start", start, 1'b0);
    model_clear();
    chk_rw("mid_rst_csr_rw");
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(4, 1'b1);
    issue(1'b0, 32'd0, 32'h0, 1'b1);
    idle(3, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
